// File: rtl/hcms_pkg.sv
// Shared types and sizing helpers for the HCMS-29xx serial link controller.
package hcms_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } hcms_state_e;

  localparam logic HCMS_DATA_REGISTER    = 1'b0;
  localparam logic HCMS_COMMAND_REGISTER = 1'b1;

  // Each device holds 4 characters x 5 columns of dot data.
  function automatic int unsigned hcms_max_bytes(input int unsigned num_devices);
    return 20 * num_devices;
  endfunction

  function automatic int unsigned hcms_len_w(input int unsigned num_devices);
    return $clog2(hcms_max_bytes(num_devices) + 1);
  endfunction

  function automatic int unsigned hcms_addr_w(input int unsigned num_devices);
    return $clog2(hcms_max_bytes(num_devices));
  endfunction

endpackage

// File: rtl/hcms_sclk_gen.sv
// Half-period timer: ticks at the end of every half period and flags the end
// of each full period (the cycle before a new low phase begins).
module hcms_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic en_i,
  output logic half_end_o,
  output logic period_start_o,
  output logic half_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;

  always_comb begin
    half_end_o     = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
    period_start_o = half_end_o && half_q;
    cnt_d          = cnt_q;
    half_d         = half_q;
    if (!en_i) begin
      cnt_d  = '0;
      half_d = 1'b0;
    end else if (half_end_o) begin
      cnt_d  = '0;
      half_d = ~half_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
    end
  end

  assign half_o = half_q;

endmodule

// File: rtl/hcms_link_ctrl.sv
// Frame sequencer for daisy-chained HCMS-29xx displays: fetches bytes from an
// external buffer and shifts them out MSB first with registered display pins.
module hcms_link_ctrl
  import hcms_pkg::*;
#(
  parameter  int unsigned NUM_DEVICES  = 1,
  parameter  int unsigned CLK_DIV      = 4,
  parameter  int unsigned RESET_CYCLES = 16,
  localparam int unsigned MAX_BYTES    = hcms_max_bytes(NUM_DEVICES),
  localparam int unsigned LEN_W        = hcms_len_w(NUM_DEVICES),
  localparam int unsigned ADDR_W       = hcms_addr_w(NUM_DEVICES)
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_start,
  input  logic              i_is_cmd,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sdata,
  output logic              o_sclk,
  output logic              o_rs,
  output logic              o_nCe,
  output logic              o_nReset
);

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  hcms_state_e       state_q, state_d;
  logic [RST_W-1:0]  init_cnt_q, init_cnt_d;
  logic              is_cmd_q, is_cmd_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] byte_q, byte_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              rd_pend_q, rd_pend_d;
  logic              nreset_q, nreset_d, nce_q, nce_d, sclk_q, sclk_d;
  logic              sdata_q, sdata_d, rs_q, rs_d, rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d, busy_q, busy_d;

  logic sg_en, sg_half_end, sg_period, sg_half;
  logic last_byte;
  logic [7:0] src;

  assign sg_en = state_q inside {S_SETUP, S_SHIFT, S_LATCH, S_HOLD};

  hcms_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .i_CLK          (i_CLK),
    .i_RST_N        (i_RST_N),
    .en_i           (sg_en),
    .half_end_o     (sg_half_end),
    .period_start_o (sg_period),
    .half_o         (sg_half)
  );

  assign last_byte = (LEN_W'(byte_q) + LEN_W'(1)) == len_q;
  // With CLK_DIV=1 the prefetched byte arrives on the very edge it is needed.
  assign src = rd_pend_q ? i_rd_data : sh_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    is_cmd_d   = is_cmd_q;
    len_d      = len_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    sh_d       = rd_pend_q ? i_rd_data : sh_q;
    rd_pend_d  = rd_en_q;
    nreset_d   = nreset_q;
    nce_d      = nce_q;
    sclk_d     = sclk_q;
    sdata_d    = sdata_q;
    rs_d       = rs_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
          nreset_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + RST_W'(1);
        end
      end
      S_IDLE: begin
        if (i_start && (i_len != '0) && (i_len <= LEN_W'(MAX_BYTES))) begin
          is_cmd_d  = i_is_cmd;
          len_d     = i_len;
          byte_d    = '0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_pend_q) begin
          rs_d    = is_cmd_q;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (sg_half_end && !sg_half) begin
          nce_d = 1'b0;
        end else if (sg_period) begin
          bit_d   = '0;
          sdata_d = src[7];
          sh_d    = {src[6:0], 1'b0};
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sg_half_end && !sg_half) begin
          sclk_d = 1'b1;
        end else if (sg_period) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7 && last_byte) begin
            state_d = S_LATCH;
          end else begin
            bit_d   = bit_q + 3'd1;
            sdata_d = src[7];
            sh_d    = {src[6:0], 1'b0};
            if (bit_q == 3'd7) byte_d = byte_q + ADDR_W'(1);
            // Prefetch as bit 7 goes out so the next byte is ready with no gap.
            if (bit_q == 3'd6 && !last_byte) begin
              rd_en_d   = 1'b1;
              rd_addr_d = byte_q + ADDR_W'(1);
            end
          end
        end
      end
      S_LATCH: begin
        if (sg_period) begin
          nce_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (sg_period) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      is_cmd_q   <= HCMS_DATA_REGISTER;
      len_q      <= '0;
      byte_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rd_pend_q  <= 1'b0;
      nreset_q   <= 1'b0;
      nce_q      <= 1'b1;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      rs_q       <= HCMS_DATA_REGISTER;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      is_cmd_q   <= is_cmd_d;
      len_q      <= len_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rd_pend_q  <= rd_pend_d;
      nreset_q   <= nreset_d;
      nce_q      <= nce_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      rs_q       <= rs_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = rd_addr_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_sdata   = sdata_q;
  assign o_sclk    = sclk_q;
  assign o_rs      = rs_q;
  assign o_nCe     = nce_q;
  assign o_nReset  = nreset_q;

endmodule

// File: tb/tb_hcms_link_ctrl.sv
// Self-checking bench for hcms_link_ctrl: vector table, random frames against a
// byte-stream reference model, and hand-written abort/ignore sequences.
module tb_hcms_link_ctrl;
  import hcms_pkg::*;

  localparam int unsigned ND    = 1;
  localparam int unsigned CD    = 2;
  localparam int unsigned RC    = 16;
  localparam int unsigned MAXB  = hcms_max_bytes(ND);
  localparam int unsigned LEN_W = hcms_len_w(ND);
  localparam int unsigned ADDR_W = hcms_addr_w(ND);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              is_cmd = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [7:0]        rd_data = '0;
  logic              o_rd_en, o_busy, o_done, o_sdata, o_sclk, o_rs, o_nCe, o_nReset;
  logic [ADDR_W-1:0] o_rd_addr;

  always #5 clk = ~clk;

  hcms_link_ctrl #(.NUM_DEVICES(ND), .CLK_DIV(CD), .RESET_CYCLES(RC)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_start(start), .i_is_cmd(is_cmd), .i_len(len),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(rd_data),
    .o_busy(o_busy), .o_done(o_done), .o_sdata(o_sdata), .o_sclk(o_sclk),
    .o_rs(o_rs), .o_nCe(o_nCe), .o_nReset(o_nReset)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  logic [7:0] mem [MAXB];

  // Buffer responder and pin monitor; data is valid only in the cycle after o_rd_en.
  bit   mon_bits[$];
  int   mon_addrs[$];
  int   rise_cyc[$];
  int   ncyc = 0, done_cnt = 0, nce_fall_cnt = 0, proto_err = 0, rs_at_rise = -1;
  logic prev_sclk = 1'b0, prev_nce = 1'b1, prev_rs = 1'b0;
  bit   pend = 1'b0;
  int   pend_addr = 0;

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (pend && pend_addr < int'(MAXB)) rd_data = mem[pend_addr];
    else rd_data = 8'($urandom);
    pend      = (o_rd_en === 1'b1);
    pend_addr = int'(o_rd_addr);
    if (o_rd_en === 1'b1) mon_addrs.push_back(int'(o_rd_addr));
    if (o_sclk === 1'b1 && prev_sclk === 1'b0) begin
      mon_bits.push_back(o_sdata);
      rise_cyc.push_back(ncyc);
      rs_at_rise = int'(o_rs);
    end
    if (o_nCe === 1'b0 && prev_nce === 1'b1) nce_fall_cnt++;
    if (o_done === 1'b1) done_cnt++;
    if (o_sclk === 1'b1 && o_nCe === 1'b1) proto_err++;
    if (o_nCe === 1'b0 && prev_nce === 1'b0 && o_rs !== prev_rs) proto_err++;
    prev_sclk = o_sclk;
    prev_nce  = o_nCe;
    prev_rs   = o_rs;
  end

  function automatic int model_cycles(input int ln);
    return 2 + 2 * int'(CD) * (8 * ln + 3);
  endfunction

  task automatic release_and_check_init(input string tag);
    int k = 0;
    int early_idle = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (o_nReset !== 1'b1 && k < int'(RC) + 20) begin
      if (o_busy !== 1'b1) early_idle++;
      @(negedge clk);
      k++;
    end
    check({tag, " nReset_low_cycles"}, k, RC);
    check({tag, " busy_during_init"}, early_idle, 0);
    check({tag, " busy_after_init"}, o_busy, 0);
  endtask

  task automatic run_frame(input bit cmd, input int ln, input bit exp_acc, input int exp_cyc,
                           input int poke_at, input string tag);
    int k = 0, d0, f0, nbad = 0, ngap = 0, busy_seen = 0;
    bit exp_bits[$];
    mon_bits.delete(); mon_addrs.delete(); rise_cyc.delete();
    rs_at_rise = -1;
    d0 = done_cnt;
    f0 = nce_fall_cnt;
    @(negedge clk);
    start = 1'b1; is_cmd = cmd; len = LEN_W'(ln);
    @(negedge clk);
    start = 1'b0; is_cmd = 1'($urandom); len = LEN_W'($urandom);
    if (!exp_acc) begin
      repeat (12) begin
        if (o_busy === 1'b1) busy_seen++;
        @(negedge clk);
      end
      check({tag, " reject_busy"}, busy_seen, 0);
      check({tag, " reject_done"}, done_cnt - d0, 0);
      check({tag, " reject_nce"}, nce_fall_cnt - f0, 0);
      return;
    end
    check({tag, " busy_on_accept"}, o_busy, 1);
    while (o_done !== 1'b1 && k < exp_cyc + 50) begin
      @(negedge clk);
      k++;
      if (k == poke_at) begin
        start = 1'b1; is_cmd = ~cmd; len = LEN_W'(5);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " cycles_to_done"}, k, exp_cyc);
    @(negedge clk);
    check({tag, " done_pulses"}, done_cnt - d0, 1);
    check({tag, " busy_after_done"}, o_busy, 0);
    for (int i = 0; i < ln; i++)
      for (int b = 7; b >= 0; b--) exp_bits.push_back(mem[i][b]);
    check({tag, " bit_count"}, mon_bits.size(), exp_bits.size());
    foreach (exp_bits[i]) if (i >= mon_bits.size() || mon_bits[i] != exp_bits[i]) nbad++;
    check({tag, " bit_errors"}, nbad, 0);
    check({tag, " rs"}, rs_at_rise, cmd);
    check({tag, " addr_count"}, mon_addrs.size(), ln);
    nbad = 0;
    foreach (mon_addrs[i]) if (mon_addrs[i] != i) nbad++;
    check({tag, " addr_errors"}, nbad, 0);
    for (int i = 1; i < rise_cyc.size(); i++) if (rise_cyc[i] - rise_cyc[i-1] != 2 * int'(CD)) ngap++;
    check({tag, " sclk_gaps"}, ngap, 0);
    check({tag, " nce_windows"}, nce_fall_cnt - f0, 1);
  endtask

  typedef struct {
    bit         cmd;
    int         ln;
    logic [7:0] b0;
    bit         acc;
    int         cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0;
    vecs[0] = '{cmd: 1'b1, ln: 1,  b0: 8'h81, acc: 1'b1, cyc: 46};
    vecs[1] = '{cmd: 1'b0, ln: 20, b0: 8'h00, acc: 1'b1, cyc: 654};
    vecs[2] = '{cmd: 1'b0, ln: 0,  b0: 8'h11, acc: 1'b0, cyc: 0};
    vecs[3] = '{cmd: 1'b0, ln: 21, b0: 8'h22, acc: 1'b0, cyc: 0};
    vecs[4] = '{cmd: 1'b1, ln: 2,  b0: 8'hFE, acc: 1'b1, cyc: 78};
    vecs[5] = '{cmd: 1'b0, ln: 31, b0: 8'h33, acc: 1'b0, cyc: 0};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst nReset", o_nReset, 0);
    check("rst nCe", o_nCe, 1);
    check("rst sclk", o_sclk, 0);
    check("rst sdata", o_sdata, 0);
    check("rst rs", o_rs, 0);
    check("rst rd_en", o_rd_en, 0);
    check("rst rd_addr", o_rd_addr, 0);
    check("rst done", o_done, 0);
    check("rst busy", o_busy, 1);
    release_and_check_init("init");

    foreach (vecs[v]) begin
      for (int i = 0; i < int'(MAXB); i++) mem[i] = 8'(vecs[v].b0 + 8'(i));
      run_frame(vecs[v].cmd, vecs[v].ln, vecs[v].acc, vecs[v].cyc, -1, $sformatf("vec%0d", v));
    end

    for (int i = 0; i < int'(MAXB); i++) mem[i] = 8'($urandom);
    run_frame(1'b0, 3, 1'b1, 110, 20, "start_mid_shift");

    for (int n = 0; n < 8; n++) begin
      int  ln;
      bit  cmd;
      ln  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAXB + 1, 31)) * int'($urandom_range(0, 1))
                                        : int'($urandom_range(1, MAXB));
      cmd = 1'($urandom);
      for (int i = 0; i < int'(MAXB); i++) mem[i] = 8'($urandom);
      run_frame(cmd, ln, (ln >= 1 && ln <= int'(MAXB)), model_cycles(ln), -1, $sformatf("rand%0d", n));
    end

    for (int i = 0; i < int'(MAXB); i++) mem[i] = 8'($urandom);
    @(negedge clk);
    start = 1'b1; is_cmd = 1'b1; len = LEN_W'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort nCe", o_nCe, 1);
    check("abort sclk", o_sclk, 0);
    check("abort nReset", o_nReset, 0);
    check("abort busy", o_busy, 1);
    repeat (5) @(negedge clk);
    release_and_check_init("reinit");
    check("abort no_done", done_cnt - d0, 0);

    run_frame(1'b1, 1, 1'b1, 46, -1, "after_abort");
    check("protocol_violations", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
